// File: rtl/credit_fsm_param.sv
// Vending credit state machine: one-hot credit register updated on the falling clock edge,
// accumulating two coin denominations and resolving to vend-with-change or refund.
module credit_fsm_param #(
  parameter  int unsigned PRICE  = 6,
  parameter  int unsigned COIN_A = 1,
  parameter  int unsigned COIN_B = 4,
  localparam int unsigned CW     = $clog2(PRICE + COIN_A + COIN_B)
) (
  input  logic             clk,
  input  logic             res,
  input  logic             coin_a,
  input  logic             coin_b,
  input  logic             cancel,
  output logic [PRICE-1:0] state,
  output logic [CW-1:0]    credit,
  output logic             vend,
  output logic [CW-1:0]    change,
  output logic             refund,
  output logic [CW-1:0]    refund_amt,
  output logic             err
);

  localparam logic [PRICE-1:0] S0 = PRICE'(1);

  logic [PRICE-1:0] state_q, state_d;
  logic             vend_q, vend_d;
  logic [CW-1:0]    change_q, change_d;
  logic             refund_q, refund_d;
  logic [CW-1:0]    refund_amt_q, refund_amt_d;
  logic             err_q, err_d;

  logic [CW-1:0]    cur_c;
  logic [CW-1:0]    sum_c;
  logic             legal_c;

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
  always_comb begin
    legal_c = (state_q != '0) && ((state_q & (state_q - PRICE'(1))) == '0);
  end

  // One-hot to binary credit index.
  always_comb begin
    cur_c = '0;
    for (int unsigned k = 0; k < PRICE; k++) begin
      if (state_q[k]) begin
        cur_c = CW'(k);
      end
    end
  end

  // Width CW holds PRICE-1+COIN_A+COIN_B, so this sum never wraps.
  always_comb begin
    sum_c = cur_c
          + (coin_a ? CW'(COIN_A) : '0)
          + (coin_b ? CW'(COIN_B) : '0);
  end

  // Next-state and pulse decode, repair > cancel > vend > accumulate.
  always_comb begin
    state_d      = state_q;
    vend_d       = 1'b0;
    change_d     = '0;
    refund_d     = 1'b0;
    refund_amt_d = '0;
    err_d        = 1'b0;
    if (!legal_c) begin
      err_d   = 1'b1;
      state_d = S0;
    end else if (cancel) begin
      refund_d     = 1'b1;
      refund_amt_d = sum_c;
      state_d      = S0;
    end else if (sum_c >= CW'(PRICE)) begin
      vend_d   = 1'b1;
      change_d = sum_c - CW'(PRICE);
      state_d  = S0;
    end else begin
      state_d = S0 << sum_c;
    end
  end

  always_ff @(negedge clk) begin
    if (!res) begin
      state_q      <= S0;
      vend_q       <= 1'b0;
      change_q     <= '0;
      refund_q     <= 1'b0;
      refund_amt_q <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      vend_q       <= vend_d;
      change_q     <= change_d;
      refund_q     <= refund_d;
      refund_amt_q <= refund_amt_d;
      err_q        <= err_d;
    end
  end

  assign state      = state_q;
  assign credit     = cur_c;
  assign vend       = vend_q;
  assign change     = change_q;
  assign refund     = refund_q;
  assign refund_amt = refund_amt_q;
  assign err        = err_q;

endmodule

// File: tb/tb_credit_fsm_param.sv
// Bench for credit_fsm_param: directed scenarios then random coin/cancel/reset traffic,
// compared against an integer credit model.
module tb_credit_fsm_param;

  localparam int unsigned PRICE  = 6;
  localparam int unsigned COIN_A = 1;
  localparam int unsigned COIN_B = 4;
  localparam int unsigned CW     = $clog2(PRICE + COIN_A + COIN_B);

  logic             clk;
  logic             res;
  logic             coin_a;
  logic             coin_b;
  logic             cancel;
  logic [PRICE-1:0] state;
  logic [CW-1:0]    credit;
  logic             vend;
  logic [CW-1:0]    change;
  logic             refund;
  logic [CW-1:0]    refund_amt;
  logic             err;

  int n_checks;
  int n_fail;

  // Reference model: credit as a plain integer plus expected pulse values.
  int m_credit;
  bit m_bad;
  int e_vend, e_change, e_refund, e_refund_amt, e_err;

  credit_fsm_param #(.PRICE(PRICE), .COIN_A(COIN_A), .COIN_B(COIN_B)) dut (
    .clk        (clk),
    .res        (res),
    .coin_a     (coin_a),
    .coin_b     (coin_b),
    .cancel     (cancel),
    .state      (state),
    .credit     (credit),
    .vend       (vend),
    .change     (change),
    .refund     (refund),
    .refund_amt (refund_amt),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input bit r, input bit a, input bit b, input bit c);
    int sum;
    e_vend = 0; e_change = 0; e_refund = 0; e_refund_amt = 0; e_err = 0;
    if (!r) begin
      m_credit = 0;
      m_bad    = 1'b0;
    end else if (m_bad) begin
      e_err    = 1;
      m_credit = 0;
      m_bad    = 1'b0;
    end else begin
      sum = m_credit + (a ? int'(COIN_A) : 0) + (b ? int'(COIN_B) : 0);
      if (c) begin
        e_refund     = 1;
        e_refund_amt = sum;
        m_credit     = 0;
      end else if (sum >= int'(PRICE)) begin
        e_vend   = 1;
        e_change = sum - int'(PRICE);
        m_credit = 0;
      end else begin
        m_credit = sum;
      end
    end
  endtask

  // Drive inputs (called at a rising edge), let the falling edge act, check at the next rising edge.
  task automatic step(input string tag, input bit r, input bit a, input bit b, input bit c);
    res = r; coin_a = a; coin_b = b; cancel = c;
    @(negedge clk);
    model(r, a, b, c);
    @(posedge clk);
    chk({tag, ".state"},      32'(state),      32'(1) << m_credit);
    chk({tag, ".credit"},     32'(credit),     32'(m_credit));
    chk({tag, ".vend"},       32'(vend),       32'(e_vend));
    chk({tag, ".change"},     32'(change),     32'(e_change));
    chk({tag, ".refund"},     32'(refund),     32'(e_refund));
    chk({tag, ".refund_amt"}, 32'(refund_amt), 32'(e_refund_amt));
    chk({tag, ".err"},        32'(err),        32'(e_err));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    m_credit = 0;
    m_bad    = 1'b0;
    res = 1'b0; coin_a = 1'b0; coin_b = 1'b0; cancel = 1'b0;

    step("rst0", 0, 0, 0, 0);
    chk("rst0.state_lit", 32'(state), 32'h1);

    // Reset mid-transaction with a coin present discards credit.
    step("t1a", 1, 0, 1, 0);
    chk("t1a.credit4", 32'(credit), 32'd4);
    step("t1b", 0, 0, 1, 0);
    chk("t1b.state_lit", 32'(state), 32'h1);

    // Six quarters: vend exact on the sixth.
    for (int i = 0; i < 6; i++) step("t2", 1, 1, 0, 0);
    chk("t2.vend", 32'(vend), 32'd1);
    step("t2.idle", 1, 0, 0, 0);

    // Credit 3 plus dollar: change 1, pulse lasts one cycle.
    for (int i = 0; i < 3; i++) step("t3.pre", 1, 1, 0, 0);
    step("t3.vend", 1, 0, 1, 0);
    chk("t3.change1", 32'(change), 32'd1);
    step("t3.after", 1, 0, 0, 0);

    // Both coins on one edge, then a dollar from S5: change 3.
    step("t4.both", 1, 1, 1, 0);
    chk("t4.s5", 32'(state), 32'b100000);
    step("t4.vend", 1, 0, 1, 0);
    chk("t4.change3", 32'(change), 32'd3);

    // Cancel with a same-edge coin refunds it too; cancel beats vend.
    step("t5.c1", 1, 1, 0, 0);
    step("t5.c2", 1, 1, 0, 0);
    step("t5.cancel", 1, 1, 0, 1);
    chk("t5.amt3", 32'(refund_amt), 32'd3);
    for (int i = 0; i < 5; i++) step("t5.up", 1, 1, 0, 0);
    step("t5.cancel9", 1, 0, 1, 1);
    chk("t5.amt9", 32'(refund_amt), 32'd9);

    // Illegal encoding is repaired and the coin discarded; back-to-back vend from S0.
    force dut.state_q = 6'b001010;
    #1;
    release dut.state_q;
    m_bad = 1'b1;
    step("t6.err", 1, 1, 0, 0);
    chk("t6.errlit", 32'(err), 32'd1);
    step("t6.after", 1, 0, 0, 0);
    step("b2b.a", 1, 1, 1, 0);
    step("b2b.v", 1, 1, 0, 0);
    step("b2b.n", 1, 1, 0, 0);

    // Random traffic, including occasional resets and illegal encodings.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        force dut.state_q = 6'b110000;
        #1;
        release dut.state_q;
        m_bad = 1'b1;
      end
      step("rnd", $urandom_range(0, 31) != 0, 1'($urandom), 1'($urandom),
           $urandom_range(0, 7) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
